sd_sector_streamer: RTL and testbench
=====================================

// Module: sd_sector_streamer
// PURPOSE
//  Sequences sd_controller for multi-sector reads: issues one 512-byte rd per sector
//  from start_sector for sector_count sectors. Buffers bytes in an internal FIFO and
//  presents them on a valid/ready byte stream to the video pipeline.
//  A block is issued only when the FIFO has >=512 free entries; sd_controller has no
//  mid-block backpressure. Provides completion, abort and timeout reporting.
// PARAMETERS
//  FIFO_DEPTH      1024        byte FIFO entries; power of 2, >=512
//  BYTE_ADDR       1           1: sd_address = sector<<9 (mod 2^32); 0: sd_address = sector
//  TIMEOUT_CYCLES  25_000_000  max clk cycles waiting on any single SD event
// PORTS
//  clk                in   1   25 MHz system clock, same as sd_controller
//  reset_n            in   1   asynchronous, active-low reset
//  start              in   1   1-cycle request; sampled only in IDLE
//  start_sector       in   32  first sector index, latched on start
//  sector_count       in   16  sectors to read, latched on start
//  abort              in   1   stop after current block; level, sampled every cycle
//  busy               out  1   high from accepted start until done pulse
//  done               out  1   1-cycle pulse at end of transfer (normal/abort/error)
//  error              out  1   sticky timeout/overflow flag; cleared on next accepted start
//  sectors_done       out  16  sectors fully received in current transfer
//  fifo_level         out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  m_data             out  8   stream byte (FIFO head)
//  m_valid            out  1   m_data valid; FIFO non-empty
//  m_ready            in   1   consumer accepts byte when m_valid&m_ready
//  sd_ready           in   1   sd_controller ready
//  sd_rd              out  1   read request to sd_controller
//  sd_address         out  32  address to sd_controller; stable while sd_rd high and until sd_ready falls
//  sd_dout            in   8   byte from sd_controller
//  sd_byte_available  in   1   1-cycle strobe qualifying sd_dout
// BEHAVIOUR
//  Reset values: busy=0, done=0, error=0, sectors_done=0, sd_rd=0, sd_address=0,
//   m_valid=0, fifo_level=0, FSM=IDLE, FIFO empty.
//  FSM:
//   IDLE: start=1 -> latch sector/count, clear error and sectors_done, busy=1.
//    count=0 -> FINISH; else -> WAIT_SPACE.
//   WAIT_SPACE: abort -> FINISH; free>=512 && sd_ready -> ISSUE.
//   ISSUE: sd_rd=1 (registered), sd_address = address of current sector -> WAIT_ACK.
//   WAIT_ACK: hold sd_rd until sd_ready=0, then drop sd_rd, byte_cnt=0 -> RECV.
//   RECV: each sd_byte_available pushes sd_dout and increments byte_cnt.
//    After byte 511 -> WAIT_IDLE.
//   WAIT_IDLE: wait sd_ready=1 (CRC consumed); sectors_done++, sector++.
//    sectors_done==count or abort seen -> FINISH; else -> WAIT_SPACE.
//   FINISH: done=1 for one cycle, busy=0 -> IDLE.
//  Latency: start in cycle N with empty FIFO and sd_ready=1 -> sd_rd=1 at N+2.
//  Abort during a block: block completes and its bytes enter the FIFO; no further
//   issue; error unchanged. FIFO is not flushed.
//  Timeout: a counter runs in WAIT_ACK, RECV (reloads on each byte) and WAIT_IDLE.
//   At TIMEOUT_CYCLES: error=1, sd_rd=0 -> FINISH.
//  Push into a full FIFO (must not occur): byte dropped, error=1, transfer continues.
//  FIFO: push and pop in the same cycle are both honoured and fifo_level is unchanged.
//   m_data holds stable while m_valid && !m_ready. FIFO drains in IDLE.
//  Sector index increments modulo 2^32. BYTE_ADDR=1 truncates sector<<9 to 32 bits.
//  start while busy is ignored. Bytes arriving outside RECV are dropped; error is not set.
//  reset_n low mid-transfer: immediate return to reset values, FIFO contents discarded.
// TESTING
//  T1 start, sector=5, count=1, BYTE_ADDR=1, m_ready=1 -> sd_address=0x00000A00;
//     512 bytes out in order; done at end; sectors_done=1.
//  T2 count=3, m_ready=0 -> 2nd rd issued; 3rd rd withheld while fifo_level=1024
//     (free<512). m_ready=1 -> 3rd issued; total 1536 bytes out.
//  T3 count=0 -> done at N+1, sd_rd never asserted, error=0.
//  T4 count=4, abort pulsed mid-2nd block -> 2nd block fully received;
//     sectors_done=2; done; no 3rd rd.
//  T5 model stalls bytes after 100, TIMEOUT_CYCLES=1000 -> error=1 and done
//     1000 cycles after last byte; next start clears error.
//  T6 reset_n low during RECV -> all outputs at reset values at once; sd_rd=0; fifo_level=0.

Source files
------------

// File: rtl/sd_sector_streamer.sv
// sd_sector_streamer: drives sd_controller through a run of 512-byte sector reads and
// re-emits the received bytes on a valid/ready byte stream through an internal FIFO.
// A block is requested only when the FIFO can absorb it whole, because sd_controller
// cannot be stalled mid-block.
module sd_sector_streamer #(
  parameter int unsigned FIFO_DEPTH     = 1024,
  parameter bit          BYTE_ADDR      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [31:0]                   start_sector,
  input  logic [15:0]                   sector_count,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [15:0]                   sectors_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  input  logic                          sd_ready,
  output logic                          sd_rd,
  output logic [31:0]                   sd_address,
  input  logic [7:0]                    sd_dout,
  input  logic                          sd_byte_available
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned Block = 512;

  // Highest occupancy at which a whole block still fits.
  localparam logic [LW-1:0] SpaceLimit  = LW'(FIFO_DEPTH - Block);
  localparam logic [LW-1:0] FullLevel   = LW'(FIFO_DEPTH);
  // The timer holds the number of cycles spent waiting including the current one.
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TimerOne    = TW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitSpace,
    StIssue,
    StWaitAck,
    StRecv,
    StWaitIdle,
    StFinish
  } state_e;

  state_e          state_q;
  logic [31:0]     sector_q;
  logic [15:0]     count_q;
  logic [8:0]      byte_cnt_q;
  logic [TW-1:0]   timer_q;
  logic            abort_seen_q;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;

  logic            push_req;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            timed_out;

  // Bytes are only accepted while a block is being received; strays are ignored.
  assign push_req   = (state_q == StRecv) && sd_byte_available;
  assign fifo_full  = (level_q == FullLevel);
  assign push       = push_req && !fifo_full;
  assign pop        = m_valid && m_ready;
  assign timed_out  = (timer_q == TimeoutLast);

  assign fifo_level = level_q;
  assign m_valid    = (level_q != '0);
  assign m_data     = mem[rd_ptr_q];

  function automatic logic [31:0] sector_addr(input logic [31:0] s);
    if (BYTE_ADDR) begin
      return {s[22:0], 9'd0};
    end
    return s;
  endfunction

  // FIFO storage; left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= sd_dout;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the level unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Transfer sequencer with registered handshake and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      sector_q     <= '0;
      count_q      <= '0;
      byte_cnt_q   <= '0;
      timer_q      <= '0;
      abort_seen_q <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      sectors_done <= '0;
      sd_rd        <= 1'b0;
      sd_address   <= '0;
    end else begin
      done <= 1'b0;

      // Abort is a level; remember it so the current block can finish first.
      if (busy && abort) begin
        abort_seen_q <= 1'b1;
      end

      // Should never happen since a block is only issued with room for it.
      if (push_req && fifo_full) begin
        error <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            sector_q     <= start_sector;
            count_q      <= sector_count;
            error        <= 1'b0;
            sectors_done <= '0;
            abort_seen_q <= 1'b0;
            busy         <= 1'b1;
            if (sector_count == 16'd0) begin
              done    <= 1'b1;
              state_q <= StFinish;
            end else begin
              state_q <= StWaitSpace;
            end
          end
        end

        StWaitSpace: begin
          if (abort || abort_seen_q) begin
            done    <= 1'b1;
            state_q <= StFinish;
          end else if ((level_q <= SpaceLimit) && sd_ready) begin
            sd_rd      <= 1'b1;
            sd_address <= sector_addr(sector_q);
            state_q    <= StIssue;
          end
        end

        StIssue: begin
          timer_q <= TimerOne;
          state_q <= StWaitAck;
        end

        // sd_controller acknowledges a read by dropping sd_ready.
        StWaitAck: begin
          if (!sd_ready) begin
            sd_rd      <= 1'b0;
            byte_cnt_q <= '0;
            timer_q    <= TimerOne;
            state_q    <= StRecv;
          end else if (timed_out) begin
            error   <= 1'b1;
            sd_rd   <= 1'b0;
            done    <= 1'b1;
            state_q <= StFinish;
          end else begin
            timer_q <= timer_q + TimerOne;
          end
        end

        StRecv: begin
          if (sd_byte_available) begin
            byte_cnt_q <= byte_cnt_q + 9'd1;
            timer_q    <= TimerOne;
            if (byte_cnt_q == 9'd511) begin
              state_q <= StWaitIdle;
            end
          end else if (timed_out) begin
            error   <= 1'b1;
            sd_rd   <= 1'b0;
            done    <= 1'b1;
            state_q <= StFinish;
          end else begin
            timer_q <= timer_q + TimerOne;
          end
        end

        // sd_ready returns once the controller has consumed the block CRC.
        StWaitIdle: begin
          if (sd_ready) begin
            sectors_done <= sectors_done + 16'd1;
            sector_q     <= sector_q + 32'd1;
            if ((sectors_done + 16'd1 == count_q) || abort_seen_q || abort) begin
              done    <= 1'b1;
              state_q <= StFinish;
            end else begin
              state_q <= StWaitSpace;
            end
          end else if (timed_out) begin
            error   <= 1'b1;
            sd_rd   <= 1'b0;
            done    <= 1'b1;
            state_q <= StFinish;
          end else begin
            timer_q <= timer_q + TimerOne;
          end
        end

        // done is high during this state; busy falls as we leave it.
        StFinish: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_streamer.sv
// Scoreboard bench for sd_sector_streamer: an SD controller model pushes every byte it
// sends and the reference model pushes every address it expects; monitors pop and compare.
module tb_sd_sector_streamer;

  localparam int unsigned FIFO_DEPTH     = 1024;
  localparam int unsigned TIMEOUT_CYCLES = 1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] start_sector = '0;
  logic [15:0] sector_count = '0;
  logic        abort;
  logic        busy, done, error;
  logic [15:0] sectors_done;
  logic [10:0] fifo_level;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic        sd_ready;
  logic        sd_rd;
  logic [31:0] sd_address;
  logic [7:0]  sd_dout;
  logic        sd_byte_available;

  sd_sector_streamer #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .BYTE_ADDR     (1'b1),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .start            (start),
    .start_sector     (start_sector),
    .sector_count     (sector_count),
    .abort            (abort),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .sectors_done     (sectors_done),
    .fifo_level       (fifo_level),
    .m_data           (m_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .sd_ready         (sd_ready),
    .sd_rd            (sd_rd),
    .sd_address       (sd_address),
    .sd_dout          (sd_dout),
    .sd_byte_available(sd_byte_available)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_addr[$];
  int rd_count = 0;
  int blk = 0;
  int blk_bytes = 0;
  int abort_blk = -1;
  int stall_after = -1;
  int popped = 0;
  int rmode = 0;
  int last_byte_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Consumer: m_ready pattern selected by rmode, changed just after the clock edge.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       m_ready = 1'b0;
        1:       m_ready = 1'b1;
        default: m_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Stream monitor: pops the scoreboard on each handshake and checks m_data holds.
  initial begin
    bit         hold;
    logic [7:0] hold_data;
    hold = 0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold = 0;
      end else begin
        if (hold) begin
          check("m_data hold", m_data, hold_data);
          check("m_valid hold", m_valid, 1);
        end
        if (m_valid && m_ready) begin
          if (exp_bytes.size() == 0) bound_fail("m_data with empty scoreboard");
          else check("m_data", m_data, exp_bytes.pop_front());
          popped++;
        end
        hold = m_valid && !m_ready;
        hold_data = m_data;
      end
    end
  end

  // SD controller model: acks a read by dropping sd_ready, sends 512 bytes, then a CRC gap.
  initial begin
    logic [31:0] addr;
    logic [7:0]  b;
    sd_ready = 1'b1;
    sd_byte_available = 1'b0;
    sd_dout = '0;
    abort = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && sd_rd && sd_ready) begin
        addr = sd_address;
        rd_count++;
        blk_bytes = 0;
        if (exp_addr.size() == 0) bound_fail("sd_rd not expected");
        else check("sd_address", addr, exp_addr.pop_front());
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          check("sd_address stable", sd_address, addr);
        end
        sd_ready = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 512; i++) begin
          if (stall_after >= 0 && i == stall_after) begin
            while (stall_after >= 0) @(negedge clk);
            break;
          end
          repeat ($urandom_range(0, 1)) @(negedge clk);
          if (!reset_n) break;
          b = 8'($urandom);
          sd_dout = b;
          sd_byte_available = 1'b1;
          exp_bytes.push_back(b);
          abort = (blk == abort_blk) && (i == 100);
          last_byte_cyc = cyc;
          blk_bytes = i + 1;
          @(negedge clk);
          sd_byte_available = 1'b0;
          abort = 1'b0;
          if (!reset_n) break;
        end
        sd_byte_available = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        sd_ready = 1'b1;
        blk++;
      end
    end
  end

  // Reference model: expected addresses are (sector + i) << 9 in 32-bit arithmetic.
  task automatic begin_xfer(input logic [31:0] sec, input int cnt, input int nrds);
    logic [31:0] a;
    for (int i = 0; i < nrds; i++) begin
      a = sec + 32'(i);
      exp_addr.push_back(a << 9);
    end
    rd_count = 0;
    blk = 0;
    blk_bytes = 0;
    popped = 0;
    @(negedge clk);
    start_sector = sec;
    sector_count = 16'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      if (done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) bound_fail("done");
  endtask

  task automatic drain(input int exp_total);
    int k;
    k = 0;
    while ((m_valid || exp_bytes.size() != 0) && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20000) bound_fail("drain");
    check("bytes out", popped, exp_total);
    check("addr queue left", exp_addr.size(), 0);
  endtask

  task automatic end_xfer(input int exp_sd, input bit exp_err, input int exp_rds,
                          input int exp_total);
    bit ok;
    wait_done(20000, ok);
    if (ok) begin
      check("sectors_done", sectors_done, exp_sd);
      check("error at done", error, exp_err);
      check("busy at done", busy, 1);
      @(negedge clk);
      check("done pulse width", done, 0);
      check("busy after done", busy, 0);
    end
    check("rd count", rd_count, exp_rds);
    drain(exp_total);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          k;
    int          cnt;
    logic [31:0] sec;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset sectors_done", sectors_done, 0);
    check("reset sd_rd", sd_rd, 0);
    check("reset sd_address", sd_address, 0);
    check("reset m_valid", m_valid, 0);
    check("reset fifo_level", fifo_level, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: single sector, latency to sd_rd and byte address
    rmode = 1;
    begin_xfer(32'd5, 1, 1);
    check("T1 busy N+1", busy, 1);
    check("T1 sd_rd N+1", sd_rd, 0);
    @(negedge clk);
    check("T1 sd_rd N+2", sd_rd, 1);
    check("T1 sd_address", sd_address, 32'h0000_0A00);
    end_xfer(1, 0, 1, 512);

    // T2: consumer stalled, third read withheld until space frees up
    rmode = 0;
    begin_xfer(32'd40, 3, 3);
    k = 0;
    while (fifo_level != 11'd1024 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) bound_fail("T2 fifo full");
    repeat (30) @(negedge clk);
    check("T2 rd withheld", rd_count, 2);
    check("T2 sd_rd low", sd_rd, 0);
    check("T2 level", fifo_level, 1024);
    check("T2 busy", busy, 1);
    rmode = 2;
    end_xfer(3, 0, 3, 1536);

    // T3: zero-sector transfer
    rd_count = 0;
    @(negedge clk);
    start_sector = 32'd9;
    sector_count = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("T3 done N+1", done, 1);
    check("T3 busy N+1", busy, 1);
    check("T3 error", error, 0);
    repeat (5) @(negedge clk);
    check("T3 no rd", rd_count, 0);
    check("T3 sd_rd", sd_rd, 0);

    // T4: abort during the second block; also a start while busy must be ignored
    abort_blk = 1;
    begin_xfer(32'd1000, 4, 2);
    repeat (5) @(negedge clk);
    start_sector = 32'd999;
    sector_count = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    end_xfer(2, 0, 2, 1024);
    abort_blk = -1;

    // T5: bytes stall after 100, timeout then next start clears error
    rmode = 1;
    stall_after = 100;
    begin_xfer(32'd77, 2, 1);
    wait_done(5000, ok);
    if (ok) begin
      check("T5 error", error, 1);
      check("T5 timeout latency", cyc - last_byte_cyc, TIMEOUT_CYCLES);
      check("T5 sectors_done", sectors_done, 0);
      check("T5 sd_rd", sd_rd, 0);
    end
    stall_after = -1;
    check("T5 rd count", rd_count, 1);
    drain(100);
    repeat (6) @(negedge clk);
    begin_xfer(32'd78, 1, 1);
    check("T5 error cleared", error, 0);
    end_xfer(1, 0, 1, 512);

    // T6: reset asserted while receiving
    rmode = 0;
    begin_xfer(32'd500, 2, 2);
    k = 0;
    while (blk_bytes <= 200 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) bound_fail("T6 recv");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("T6 busy", busy, 0);
    check("T6 done", done, 0);
    check("T6 error", error, 0);
    check("T6 sectors_done", sectors_done, 0);
    check("T6 sd_rd", sd_rd, 0);
    check("T6 sd_address", sd_address, 0);
    check("T6 m_valid", m_valid, 0);
    check("T6 fifo_level", fifo_level, 0);
    repeat (5) @(negedge clk);
    exp_bytes.delete();
    exp_addr.delete();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Randomized transfers, one of them wrapping the sector index past 2^32-1
    rmode = 2;
    for (int t = 0; t < 5; t++) begin
      sec = (t == 2) ? 32'hFFFF_FFFF : $urandom;
      cnt = (t == 2) ? 2 : int'($urandom_range(1, 3));
      begin_xfer(sec, cnt, cnt);
      end_xfer(cnt, 0, cnt, cnt * 512);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
